// File: rtl/ysyx_22050612_ifu_prefetch.sv
// Pipelined instruction fetch with an in-order prefetch queue between PC redirect logic and decode.
// Optional performance counters are enabled by defining YSYX_22050612_IFU_PERF_EN.
module ysyx_22050612_ifu_prefetch #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
  parameter int unsigned     MEM_W    = 64,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             redirect_valid_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic [XLEN-1:0]  mem_req_addr_o,
  input  logic             mem_resp_valid_i,
  input  logic [MEM_W-1:0] mem_resp_data_i,
  output logic             inst_valid_o,
  input  logic             inst_ready_i,
  output logic [31:0]      inst_o,
  output logic [XLEN-1:0]  inst_pc_o
`ifdef YSYX_22050612_IFU_PERF_EN
  ,
  output logic [63:0]      perf_fetch_cnt_o,
  output logic [63:0]      perf_stall_cnt_o
`endif
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DROP_W = 16;
  localparam int unsigned OFF_W  = $clog2(MEM_W / 8);

  logic [XLEN-1:0]   pc_q   [DEPTH];
  logic [31:0]       inst_q [DEPTH];
  logic [DEPTH-1:0]  filled_q;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  alloc_q, alloc_d, fill_q, fill_d, read_q, read_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [CNT_W-1:0]  count, unfilled;
  logic [PTR_W-1:0]  alloc_idx, fill_idx, read_idx;
  logic              req_hs, inst_hs, resp_fill;
  logic [31:0]       resp_inst;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign alloc_idx = alloc_q[PTR_W-1:0];
  assign fill_idx  = fill_q[PTR_W-1:0];
  assign read_idx  = read_q[PTR_W-1:0];
  assign count     = alloc_q - read_q;
  assign unfilled  = alloc_q - fill_q;

  assign mem_req_valid_o = rst_ni & ~redirect_valid_i & (count < CNT_W'(DEPTH));
  assign mem_req_addr_o  = {fetch_pc_q[XLEN-1:OFF_W], OFF_W'(0)};
  assign inst_valid_o    = filled_q[read_idx] & (count != '0) & ~redirect_valid_i;
  assign inst_o          = inst_q[read_idx];
  assign inst_pc_o       = pc_q[read_idx];

  assign req_hs    = mem_req_valid_o & mem_req_ready_i;
  assign inst_hs   = inst_valid_o & inst_ready_i;
  assign resp_fill = mem_resp_valid_i & ~redirect_valid_i & (drop_q == '0);

  // Wide memory returns an aligned pair; pc[2] picks the upper word.
  generate
    if (MEM_W == 64) begin : g_wide
      assign resp_inst = pc_q[fill_idx][2] ? mem_resp_data_i[MEM_W-1 -: 32] : mem_resp_data_i[31:0];
    end else begin : g_narrow
      assign resp_inst = mem_resp_data_i[31:0];
    end
  endgenerate

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    read_d     = read_q;
    drop_d     = drop_q;
    if (redirect_valid_i) begin
      // Every request still in flight must be discarded when it returns.
      fetch_pc_d = redirect_pc_i & ~XLEN'(3);
      alloc_d    = '0;
      fill_d     = '0;
      read_d     = '0;
      drop_d     = drop_q + DROP_W'(unfilled) - DROP_W'(mem_resp_valid_i);
    end else begin
      if (req_hs) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        alloc_d    = alloc_q + CNT_W'(1);
      end
      if (resp_fill) begin
        fill_d = fill_q + CNT_W'(1);
      end else if (mem_resp_valid_i) begin
        drop_d = drop_q - DROP_W'(1);
      end
      if (inst_hs) begin
        read_d = read_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      alloc_q    <= '0;
      fill_q     <= '0;
      read_q     <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      read_q     <= read_d;
      drop_q     <= drop_d;
    end
  end

  // Queue storage; alloc and fill never target the same slot in one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filled_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else if (!redirect_valid_i) begin
      if (req_hs) begin
        pc_q[alloc_idx]     <= fetch_pc_q;
        filled_q[alloc_idx] <= 1'b0;
      end
      if (resp_fill) begin
        inst_q[fill_idx]   <= resp_inst;
        filled_q[fill_idx] <= 1'b1;
      end
    end
  end

`ifdef YSYX_22050612_IFU_PERF_EN
  // Counters survive redirects; only reset clears them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_fetch_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (inst_hs) begin
        perf_fetch_cnt_o <= perf_fetch_cnt_o + 64'd1;
      end
      if (inst_ready_i && !inst_valid_o && !redirect_valid_i) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 64'd1;
      end
    end
  end
`endif

endmodule
